// File: rtl/fsm_eg_stim_gen.sv
// fsm_eg_stim_gen
//   Stimulus driver and response checker for the two-input, three-state
//   example FSM. It replays a latched (a,b) pattern into the FSM one step per
//   clock, runs a golden copy of that FSM in lock-step, compares the returned
//   y0/y1 on every driven cycle, and leaves the FSM in s0 when a run ends.
//
//   Build option: define FSM_EG_CHECK_EN to compile in the golden-model
//   comparison and the err/err_cnt registers. Without it err/err_cnt are
//   constant zero and y0_in/y1_in are ignored; stimulus is unchanged.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   run request, sampled only when idle (or in the done cycle)
//   len        in   number of steps minus 1
//   pat_a      in   bit i is 'a' for step i
//   pat_b      in   bit i is 'b' for step i
//   a, b       out  registered drive to the FSM
//   y0_in      in   FSM Mealy output
//   y1_in      in   FSM Moore output
//   busy       out  high while stimulus is driven and checked
//   done_tick  out  one-cycle pulse after the last compared cycle
//   err        out  sticky mismatch flag
//   err_cnt    out  saturating mismatch count
module fsm_eg_stim_gen #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] len,
  input  logic [DEPTH-1:0]         pat_a,
  input  logic [DEPTH-1:0]         pat_b,
  output logic                     a,
  output logic                     b,
  input  logic                     y0_in,
  input  logic                     y1_in,
  output logic                     busy,
  output logic                     done_tick,
  output logic                     err,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int unsigned LW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} ctl_e;
  typedef enum logic [1:0] {M_S0, M_S1, M_S2} mdl_e;

  ctl_e             ctl_q;
  mdl_e             mdl_q, mdl_d;
  logic             a_q, b_q;
  logic             busy_q, done_q;
  logic [LW-1:0]    step_q, step_nx;
  logic [LW-1:0]    len_q;
  logic [DEPTH-1:0] pat_a_q, pat_b_q;

  // Golden model next state, driven by the registered a/b the FSM sees.
  always_comb begin
    mdl_d = M_S0;
    case (mdl_q)
      M_S0: begin
        if (a_q && b_q)      mdl_d = M_S2;
        else if (a_q)        mdl_d = M_S1;
        else                 mdl_d = M_S0;
      end
      M_S1:    mdl_d = a_q ? M_S0 : M_S1;
      default: mdl_d = M_S0;
    endcase
  end

  assign step_nx = step_q + LW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q   <= ST_IDLE;
      mdl_q   <= M_S0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
      len_q   <= '0;
      pat_a_q <= '0;
      pat_b_q <= '0;
    end else begin
      mdl_q  <= mdl_d;
      done_q <= 1'b0;
      case (ctl_q)
        // The done cycle behaves as idle so a new run can begin at the edge
        // that ends the done_tick pulse.
        ST_IDLE, ST_DONE: begin
          ctl_q  <= ST_IDLE;
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            ctl_q   <= ST_RUN;
            len_q   <= len;
            pat_a_q <= pat_a;
            pat_b_q <= pat_b;
            step_q  <= '0;
            a_q     <= pat_a[0];
            b_q     <= pat_b[0];
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (step_q == len_q) begin
            // Leaving the FSM in s1 would strand it; one (1,0) cycle fixes it.
            if (mdl_d == M_S1) begin
              ctl_q <= ST_FLUSH;
              a_q   <= 1'b1;
              b_q   <= 1'b0;
            end else begin
              ctl_q  <= ST_DONE;
              a_q    <= 1'b0;
              b_q    <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            step_q <= step_nx;
            a_q    <= pat_a_q[step_nx];
            b_q    <= pat_b_q[step_nx];
          end
        end
        ST_FLUSH: begin
          ctl_q  <= ST_DONE;
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          ctl_q  <= ST_IDLE;
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done_tick = done_q;

`ifdef FSM_EG_CHECK_EN
  logic             exp_y0, exp_y1, mism, take, checking;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    exp_y0 = 1'b0;
    exp_y1 = 1'b0;
    case (mdl_q)
      M_S0: begin
        exp_y1 = 1'b1;
        exp_y0 = a_q & b_q;
      end
      M_S1:    exp_y1 = 1'b1;
      default: ;
    endcase
  end

  assign mism     = (y0_in != exp_y0) || (y1_in != exp_y1);
  assign take     = start && ((ctl_q == ST_IDLE) || (ctl_q == ST_DONE));
  assign checking = (ctl_q == ST_RUN) || (ctl_q == ST_FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (take) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (checking && mism) begin
      err_q <= 1'b1;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err     = err_q;
  assign err_cnt = cnt_q;
`else
  logic unused_y;
  assign unused_y = y0_in ^ y1_in;
  assign err      = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule
